// File: rtl/audio_pcm_player.sv
// PCM sample player: a valid/ready FIFO feeds a fixed-rate sample clock, and a gain
// stage with saturation drives a held 16-bit output for the one-bit DAC.
module audio_pcm_player #(
  parameter int DEPTH      = 16,
  parameter int SAMPLE_DIV = 1042
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [15:0]       s_data,
  input  logic [7:0]               gain,
  output logic signed [15:0]       pcm_out,
  output logic                     tick,
  output logic                     underrun,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(SAMPLE_DIV);
  localparam logic [CW-1:0] DIV_LAST = CW'(SAMPLE_DIV - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic [CW-1:0]        div_q, div_d;
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]        level_q, level_d;
  logic                 full_q;
  logic signed [15:0]   mem [DEPTH];
  logic signed [15:0]   st1_q;
  logic                 st1_vld_q;
  logic                 underrun_q;
  logic signed [15:0]   pcm_q, pcm_d;
  logic                 push, pop;
  logic signed [24:0]   st1_ext, gain_ext, prod, shifted;

  assign tick = en && (div_q == DIV_LAST);

  // Ready comes only from the registered full flag, so a pop in the same
  // cycle never opens a slot for a push into a full FIFO.
  assign push = s_valid && !full_q;
  assign pop  = tick && (level_q != '0);

  always_comb begin
    div_d = div_q + CW'(1);
    if (!en || tick) begin
      div_d = '0;
    end
  end

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (!push && pop) begin
      level_d = level_q - LW'(1);
    end
  end

  assign st1_ext  = 25'(st1_q);
  assign gain_ext = {17'b0, gain};
  assign prod     = st1_ext * gain_ext;
  assign shifted  = prod >>> 7;

  always_comb begin
    pcm_d = shifted[15:0];
    if (shifted > 25'sd32767) begin
      pcm_d = 16'sh7fff;
    end else if (shifted < -25'sd32768) begin
      pcm_d = 16'sh8000;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= s_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      st1_q      <= '0;
      st1_vld_q  <= 1'b0;
      underrun_q <= 1'b0;
      pcm_q      <= '0;
    end else begin
      div_q   <= div_d;
      level_q <= level_d;
      full_q  <= (level_d == LVL_FULL);
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      underrun_q <= tick && (level_q == '0);
      // An empty FIFO at a tick still advances the pipeline, carrying silence.
      if (!en) begin
        st1_q     <= '0;
        st1_vld_q <= 1'b0;
      end else if (tick) begin
        st1_q     <= pop ? mem[rd_ptr_q] : 16'sd0;
        st1_vld_q <= 1'b1;
      end else begin
        st1_vld_q <= 1'b0;
      end
      if (!en) begin
        pcm_q <= '0;
      end else if (st1_vld_q) begin
        pcm_q <= pcm_d;
      end
    end
  end

  assign s_ready  = !full_q;
  assign pcm_out  = pcm_q;
  assign underrun = underrun_q;
  assign level    = level_q;

endmodule

// File: tb/tb_audio_pcm_player.sv
// Scoreboard bench for audio_pcm_player: the driver queues hand-computed outputs as
// samples are accepted; a monitor pops one entry per tick and checks latency and value.
module tb_audio_pcm_player;
  localparam int DEPTH = 16;
  localparam int SDIV  = 1042;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               en = 1'b0;
  logic               s_valid = 1'b0;
  logic signed [15:0] s_data = '0;
  logic [7:0]         gain = 8'd128;
  logic               s_ready, tick, underrun;
  logic signed [15:0] pcm_out;
  logic [4:0]         level;

  int chk_cnt = 0;
  int pass_cnt = 0;
  logic signed [15:0] exp_q[$];

  always #5 clk = ~clk;

  audio_pcm_player #(.DEPTH(DEPTH), .SAMPLE_DIV(SDIV)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .gain(gain), .pcm_out(pcm_out), .tick(tick),
    .underrun(underrun), .level(level)
  );

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic logic signed [15:0] v(input int i);
    return 16'(i * 1500 - 12000);
  endfunction

  // Monitor: per tick, expect underrun next cycle, held output next cycle, new output after two.
  int cyc = 0, start_cyc = 0, last_tick = 0;
  bit p1 = 0, p2 = 0, p1_under = 0, en_prev = 0, act_prev = 0, first_pending = 0;
  logic signed [15:0] p1_val = '0, p2_val = '0, last_exp = '0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      p1 = 0; p2 = 0; last_exp = '0;
    end else begin
      if (!en_prev) last_exp = '0;
      if (p2) begin
        check("pcm_value", int'(pcm_out), int'(p2_val));
        $display("sample out: expected %0d got %0d (cycle %0d)", p2_val, pcm_out, cyc);
        last_exp = p2_val;
      end
      if (p1) begin
        check("underrun_flag", int'(underrun), int'(p1_under));
        check("pcm_hold", int'(pcm_out), int'(last_exp));
      end
      p2 = p1; p2_val = p1_val; p1 = 0;
      if (tick) begin
        p1 = 1;
        if (exp_q.size() == 0) begin
          p1_under = 1; p1_val = '0;
        end else begin
          p1_under = 0; p1_val = exp_q.pop_front();
        end
      end
    end
    if ((en && rst_n) && !act_prev) begin
      start_cyc = cyc; first_pending = 1;
    end
    if (tick && rst_n) begin
      if (first_pending) check("tick_first", cyc - start_cyc, SDIV - 1);
      else check("tick_period", cyc - last_tick, SDIV);
      first_pending = 0; last_tick = cyc;
    end
    act_prev = en && rst_n;
    en_prev = en && rst_n;
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_wait(input logic signed [15:0] d, input logic signed [15:0] e);
    bit done = 0;
    bit rdy;
    s_valid = 1'b1; s_data = d;
    for (int c = 0; c < 2 * SDIV + 10 && !done; c++) begin
      @(negedge clk); rdy = s_ready;
      @(posedge clk);
      if (rdy) begin exp_q.push_back(e); done = 1; end
      #1;
    end
    check("push_accept", int'(done), 1);
  endtask

  task automatic wait_ticks(input int n);
    int seen = 0;
    for (int c = 0; c < n * SDIV + 20 && seen < n; c++) begin
      @(negedge clk);
      if (tick) seen++;
    end
    check("tick_wait", seen, n);
    step(3);
  endtask

  task automatic wait_empty(input int max_ticks);
    int c = 0;
    while (level != 0 && c < max_ticks * SDIV) begin @(negedge clk); c++; end
    check("drain_level", int'(level), 0);
    step(3);
  endtask

  initial begin
    #(95000 * 10);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  logic signed [15:0] g_smp [8] = '{16'sd20000, -16'sd20000, 16'sd1000, -16'sd1000,
                                    -16'sd1, -16'sd3, 16'sd3, 16'sd12345};
  logic [7:0]         g_gn  [8] = '{8'd255, 8'd255, 8'd64, 8'd64, 8'd128, 8'd1, 8'd1, 8'd0};
  logic signed [15:0] g_exp [8] = '{16'sd32767, -16'sd32768, 16'sd500, -16'sd500,
                                    -16'sd1, -16'sd1, 16'sd0, 16'sd0};

  initial begin
    int acc;
    bit rdy, found;
    // Reset state
    step(2);
    check("rst_level", int'(level), 0);
    check("rst_ready", int'(s_ready), 1);
    check("rst_pcm", int'(pcm_out), 0);
    check("rst_tick", int'(tick), 0);
    check("rst_underrun", int'(underrun), 0);
    rst_n = 1'b1; en = 1'b1; gain = 8'd128;

    // Four samples at unity gain, played in order
    push_wait(16'sd1000, 16'sd1000);
    push_wait(-16'sd1000, -16'sd1000);
    push_wait(16'sd32767, 16'sd32767);
    push_wait(-16'sd32768, -16'sd32768);
    s_valid = 1'b0;
    check("t1_level", int'(level), 4);
    wait_ticks(4);

    // Empty FIFO: underrun each tick, silence out
    wait_ticks(3);
    check("t2_level", int'(level), 0);
    check("t2_pcm", int'(pcm_out), 0);

    // Fill past capacity while muted, then play through pointer wrap
    en = 1'b0;
    step(1);
    acc = 0; s_valid = 1'b1;
    for (int c = 0; c < DEPTH + 4; c++) begin
      s_data = v(acc);
      @(negedge clk); rdy = s_ready;
      @(posedge clk);
      if (rdy) begin exp_q.push_back(v(acc)); acc++; end
      #1;
    end
    check("t3_accepts", acc, DEPTH);
    check("t3_ready_full", int'(s_ready), 0);
    check("t3_level_full", int'(level), DEPTH);
    check("t3_mute_pcm", int'(pcm_out), 0);
    s_data = v(acc); en = 1'b1;
    found = 0;
    for (int c = 0; c < SDIV + 10 && !found; c++) begin
      @(negedge clk);
      if (tick) found = 1;
    end
    check("t3_first_tick", int'(found), 1);
    check("t3_ready_at_tick", int'(s_ready), 0);
    check("t3_level_at_tick", int'(level), DEPTH);
    @(negedge clk); rdy = s_ready;
    check("t3_ready_after_pop", int'(rdy), 1);
    check("t3_level_after_pop", int'(level), DEPTH - 1);
    @(posedge clk);
    if (rdy) begin exp_q.push_back(v(acc)); acc++; end
    #1;
    while (acc < DEPTH + 4) begin
      push_wait(v(acc), v(acc));
      acc++;
    end
    s_valid = 1'b0;
    wait_empty(25);

    // Gain and saturation vectors
    for (int i = 0; i < 8; i++) begin
      gain = g_gn[i];
      push_wait(g_smp[i], g_exp[i]);
      s_valid = 1'b0;
      wait_ticks(1);
    end

    // Push coincident with tick at level DEPTH-1
    en = 1'b0; gain = 8'd128;
    step(1);
    for (int i = 0; i < DEPTH - 1; i++) push_wait(16'(v(i) + 7), 16'(v(i) + 7));
    s_valid = 1'b0;
    check("t5a_level_pre", int'(level), DEPTH - 1);
    en = 1'b1;
    step(SDIV - 1);
    s_valid = 1'b1; s_data = 16'sd777;
    @(negedge clk);
    check("t5a_tick", int'(tick), 1);
    check("t5a_ready", int'(s_ready), 1);
    @(posedge clk); exp_q.push_back(16'sd777); #1;
    s_valid = 1'b0;
    @(negedge clk);
    check("t5a_level_post", int'(level), DEPTH - 1);
    wait_empty(20);

    // Push into empty FIFO coincident with tick
    en = 1'b0;
    step(1);
    en = 1'b1;
    step(SDIV - 1);
    s_valid = 1'b1; s_data = -16'sd4321;
    @(negedge clk);
    check("t5b_tick", int'(tick), 1);
    check("t5b_level_pre", int'(level), 0);
    @(posedge clk); exp_q.push_back(-16'sd4321); #1;
    s_valid = 1'b0;
    @(negedge clk);
    check("t5b_level_post", int'(level), 1);
    check("t5b_underrun", int'(underrun), 1);
    wait_ticks(1);

    // Reset mid-playback with level 7
    en = 1'b0;
    step(1);
    for (int i = 0; i < 8; i++) push_wait(16'(v(i) - 500), 16'(v(i) - 500));
    s_valid = 1'b0;
    en = 1'b1;
    wait_ticks(1);
    check("t6_level_pre", int'(level), 7);
    rst_n = 1'b0;
    #1;
    check("t6_level", int'(level), 0);
    check("t6_pcm", int'(pcm_out), 0);
    check("t6_ready", int'(s_ready), 1);
    check("t6_underrun", int'(underrun), 0);
    step(3);
    rst_n = 1'b1;
    check("t6_level_rel", int'(level), 0);
    wait_ticks(1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
